fwd_hazard_unit: RTL

- Parametrised successor to the 2-operand EX-stage forwarding control of the RV32 pipeline.
- Generalises forwarding to NUM_SRC source operands and suppresses forwarding from x0.
- Adds load-use hazard detection with a multi-cycle stall state machine (LOAD_LAT bubbles), branch-flush override and a saturating stall-cycle counter.
- Sits beside the ID/EX pipeline register; drives the EX operand muxes, PC/IF-ID hold and ID/EX bubble insert.

---
 rtl/fwd_hazard_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use hazard control for the RV32 pipeline.
// Drives the EX operand muxes, the PC/IF-ID hold and the ID/EX bubble insert.
module fwd_hazard_unit #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_SRC*ADDR_W-1:0]   i_rs_addr_ex,
    input  logic [NUM_SRC*ADDR_W-1:0]   i_rs_addr_id,
    input  logic [NUM_SRC-1:0]          i_rs_used_id,
    input  logic [ADDR_W-1:0]           i_ex_rd_addr,
    input  logic                        i_ex_is_load,
    input  logic [ADDR_W-1:0]           i_mem_rd_addr,
    input  logic                        i_rd_wren_mem,
    input  logic [ADDR_W-1:0]           i_wb_rd_addr,
    input  logic                        i_rd_wren_wb,
    input  logic                        i_br_flush,
    output logic [NUM_SRC*2-1:0]        o_forwarding,
    output logic                        o_stall,
    output logic                        o_flush_id_ex,
    output logic [CNT_W-1:0]            o_stall_cnt
);

    typedef enum logic {StIdle, StStall} state_e;

    localparam logic [2:0]       RemInit = 3'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CntOne  = 1;

    state_e           state_q, state_d;
    logic [2:0]       rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_fwd_ok, wb_fwd_ok;
    logic             src_hit;
    logic             hz;

    // x0 is hard-wired to zero, so a write to it must never be forwarded.
    assign mem_fwd_ok = i_rd_wren_mem && (i_mem_rd_addr != '0);
    assign wb_fwd_ok  = i_rd_wren_wb && (i_wb_rd_addr != '0);

    always_comb begin
        o_forwarding = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (mem_fwd_ok && (i_mem_rd_addr == i_rs_addr_ex[k*ADDR_W +: ADDR_W])) begin
                o_forwarding[2*k +: 2] = 2'b10;
            end else if (wb_fwd_ok && (i_wb_rd_addr == i_rs_addr_ex[k*ADDR_W +: ADDR_W])) begin
                o_forwarding[2*k +: 2] = 2'b01;
            end
        end
    end

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (i_rs_used_id[k] && (i_rs_addr_id[k*ADDR_W +: ADDR_W] == i_ex_rd_addr)) begin
                src_hit = 1'b1;
            end
        end
    end

    assign hz = i_ex_is_load && (i_ex_rd_addr != '0) && src_hit;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        o_stall       = 1'b0;
        o_flush_id_ex = 1'b0;
        if (i_br_flush) begin
            // Redirect discards the dependent instruction, so any pending stall is moot.
            o_flush_id_ex = 1'b1;
            state_d       = StIdle;
            rem_d         = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hz) begin
                        o_stall       = 1'b1;
                        o_flush_id_ex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = StStall;
                            rem_d   = RemInit;
                        end
                    end
                end
                StStall: begin
                    o_stall       = 1'b1;
                    o_flush_id_ex = 1'b1;
                    rem_d         = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end
            endcase
        end
    end

    assign cnt_d = (o_stall && (cnt_q != '1)) ? cnt_q + CntOne : cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stall_cnt = cnt_q;

endmodule
